// File: rtl/moore_sequence_generator.sv
// Moore-style serial pattern generator: shifts out a captured pattern MSB-first,
// repeats it with an optional idle gap between copies, then pulses done.
// All outputs come straight from registers.
module moore_sequence_generator #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    input  logic [3:0]       repeat_cnt,
    output logic             x_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [3:0] LEN_MAX = 4'(WIDTH);
    localparam logic [3:0] GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_pat, w_pat_nx;
    logic [3:0]       r_len, w_len_nx;
    logic [3:0]       r_bit, w_bit_nx;
    logic [3:0]       r_rep, w_rep_nx;
    logic [3:0]       r_gap, w_gap_nx;
    logic             r_x, w_x_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;

    logic [3:0]       w_len_eff;
    logic [3:0]       w_sel;
    logic [WIDTH-1:0] w_in_sh;
    logic [WIDTH-1:0] w_cap_sh;

    // Zero or oversize lengths fall back to the full pattern width.
    assign w_len_eff = ((len == 4'd0) || (len > LEN_MAX)) ? LEN_MAX : len;
    assign w_in_sh   = pattern >> (w_len_eff - 4'd1);

    // Next bit from the captured copy: walk down while bits remain, otherwise
    // restart at the top (used both for back-to-back repeats and after a gap).
    assign w_sel    = (r_bit != 4'd0) ? (r_bit - 4'd1) : (r_len - 4'd1);
    assign w_cap_sh = r_pat >> w_sel;

    // State and output registers; reset is asynchronous and wipes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_len   <= 4'd0;
            r_bit   <= 4'd0;
            r_rep   <= 4'd0;
            r_gap   <= 4'd0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pat   <= w_pat_nx;
            r_len   <= w_len_nx;
            r_bit   <= w_bit_nx;
            r_rep   <= w_rep_nx;
            r_gap   <= w_gap_nx;
            r_x     <= w_x_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next-state and next-output decode; outputs are registered so they
    // reflect the state being entered.
    always_comb begin
        w_state_nx = r_state;
        w_pat_nx   = r_pat;
        w_len_nx   = r_len;
        w_bit_nx   = r_bit;
        w_rep_nx   = r_rep;
        w_gap_nx   = r_gap;
        w_x_nx     = r_x;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_x_nx    = 1'b0;
                w_busy_nx = 1'b0;
                if (start) begin
                    w_pat_nx   = pattern;
                    w_len_nx   = w_len_eff;
                    w_rep_nx   = repeat_cnt;
                    w_bit_nx   = w_len_eff - 4'd1;
                    w_x_nx     = w_in_sh[0];
                    w_busy_nx  = 1'b1;
                    w_state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit != 4'd0) begin
                    w_bit_nx = r_bit - 4'd1;
                    w_x_nx   = w_cap_sh[0];
                end else if (r_rep != 4'd0) begin
                    w_rep_nx = r_rep - 4'd1;
                    if (GAP > 0) begin
                        w_state_nx = ST_GAP;
                        w_gap_nx   = GAP_LD;
                        w_x_nx     = 1'b0;
                    end else begin
                        w_bit_nx = r_len - 4'd1;
                        w_x_nx   = w_cap_sh[0];
                    end
                end else begin
                    w_state_nx = ST_DONE;
                    w_x_nx     = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap == 4'd0) begin
                    w_state_nx = ST_SHIFT;
                    w_bit_nx   = r_len - 4'd1;
                    w_x_nx     = w_cap_sh[0];
                end else begin
                    w_gap_nx = r_gap - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                w_x_nx     = 1'b0;
                w_busy_nx  = 1'b0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_x_nx     = 1'b0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign x_out = r_x;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_moore_sequence_generator.sv
// Bench for moore_sequence_generator: a GAP=1 and a GAP=0 instance share the
// same stimulus; each is compared every cycle against an arithmetic model.
module tb_moore_sequence_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic       x_g1, b_g1, d_g1;
    logic       x_g0, b_g0, d_g0;

    moore_sequence_generator #(.WIDTH(8), .GAP(1)) u_g1 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_cnt(repeat_cnt), .x_out(x_g1), .busy(b_g1), .done(d_g1)
    );

    moore_sequence_generator #(.WIDTH(8), .GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_cnt(repeat_cnt), .x_out(x_g0), .busy(b_g0), .done(d_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Index 0 models GAP=1, index 1 models GAP=0. A transmission is described by
    // its cycle number n (1 = first bit) and the captured parameters.
    logic       m_act [2];
    int         m_n   [2];
    logic [7:0] m_p   [2];
    int         m_le  [2];
    int         m_rc  [2];
    logic [2:0] exp_o [2];   // {x_out, busy, done}

    function automatic int gap_of(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int le_of(logic [3:0] l);
        return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    endfunction

    function automatic int total_of(int le, int rc, int g);
        return (rc + 1) * le + rc * g;
    endfunction

    function automatic logic [2:0] seq_at(int n, logic [7:0] p, int le, int rc, int g);
        int         tot;
        int         pos;
        logic [7:0] s;
        tot = total_of(le, rc, g);
        if (n >= 1 && n <= tot) begin
            pos = (n - 1) % (le + g);
            if (pos < le) begin
                s = p >> (le - 1 - pos);
                return {s[0], 1'b1, 1'b0};
            end
            return 3'b010;
        end
        if (n == tot + 1) return 3'b001;
        return 3'b000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_n[i]   <= 0;
                exp_o[i] <= 3'b000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && (m_n[i] + 1 <= total_of(m_le[i], m_rc[i], gap_of(i)) + 1)) begin
                    m_n[i]   <= m_n[i] + 1;
                    exp_o[i] <= seq_at(m_n[i] + 1, m_p[i], m_le[i], m_rc[i], gap_of(i));
                end else if (m_act[i]) begin
                    m_act[i] <= 1'b0;
                    exp_o[i] <= 3'b000;
                end else if (start) begin
                    m_act[i] <= 1'b1;
                    m_n[i]   <= 1;
                    m_p[i]   <= pattern;
                    m_le[i]  <= le_of(len);
                    m_rc[i]  <= int'(repeat_cnt);
                    exp_o[i] <= seq_at(1, pattern, le_of(len), int'(repeat_cnt), gap_of(i));
                end else begin
                    exp_o[i] <= 3'b000;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int npass = 0;
    int nchk  = 0;
    int bc0, bc1, dc0, dc1;

    task automatic chk(string tag);
        nchk++;
        assert ({x_g1, b_g1, d_g1} === exp_o[0]) npass++;
        else $error("FAIL %s gap1 {x,busy,done} got %b want %b", tag, {x_g1, b_g1, d_g1}, exp_o[0]);
        nchk++;
        assert ({x_g0, b_g0, d_g0} === exp_o[1]) npass++;
        else $error("FAIL %s gap0 {x,busy,done} got %b want %b", tag, {x_g0, b_g0, d_g0}, exp_o[1]);
    endtask

    task automatic chk_int(string tag, int got, int want);
        nchk++;
        assert (got == want) npass++;
        else $error("FAIL %s got %0d want %0d", tag, got, want);
    endtask

    task automatic clr_cnt();
        bc0 = 0; bc1 = 0; dc0 = 0; dc1 = 0;
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #2;
        chk(tag);
        if (b_g1) bc0++;
        if (b_g0) bc1++;
        if (d_g1) dc0++;
        if (d_g0) dc1++;
    endtask

    task automatic run(string tag, int n);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic go(string tag, logic [7:0] p, logic [3:0] l, logic [3:0] r);
        pattern    = p;
        len        = l;
        repeat_cnt = r;
        start      = 1'b1;
        tick(tag);
        start      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst        = 1'b1;
        start      = 1'b1;
        pattern    = 8'hFF;
        len        = 4'd4;
        repeat_cnt = 4'd2;
        run("reset_hold", 3);
        start = 1'b0;
        #2 rst = 1'b0;
        run("post_reset_idle", 2);

        // 3-bit pattern, single transmission: 1,0,1 then done then idle
        clr_cnt();
        go("p101", 8'b0000_0101, 4'd3, 4'd0);
        run("p101", 5);
        chk_int("p101_busy_g1", bc0, 3);
        chk_int("p101_busy_g0", bc1, 3);
        chk_int("p101_done_g1", dc0, 1);

        // len=0 means full width; two copies with a one-cycle gap
        clr_cnt();
        go("pA5", 8'hA5, 4'd0, 4'd1);
        run("pA5", 19);
        chk_int("pA5_busy_g1", bc0, 17);
        chk_int("pA5_busy_g0", bc1, 16);
        chk_int("pA5_done_g1", dc0, 1);
        chk_int("pA5_done_g0", dc1, 1);

        // three back-to-back copies of 110
        clr_cnt();
        go("p110", 8'b0000_0110, 4'd3, 4'd2);
        run("p110", 13);
        chk_int("p110_busy_g0", bc1, 9);
        chk_int("p110_busy_g1", bc0, 11);

        // start re-pulsed and inputs changed mid-transmission must be ignored
        clr_cnt();
        go("midchg", 8'hC3, 4'd8, 4'd0);
        tick("midchg");
        pattern = 8'h3C; len = 4'd2; repeat_cnt = 4'd5; start = 1'b1;
        tick("midchg");
        start = 1'b0; pattern = 8'h00;
        run("midchg", 8);
        chk_int("midchg_busy_g1", bc0, 8);
        chk_int("midchg_done_g1", dc0, 1);

        // start held through done is taken on the first idle edge
        pattern = 8'b10; len = 4'd2; repeat_cnt = 4'd0; start = 1'b1;
        run("hold_start", 6);
        start = 1'b0;
        run("hold_start", 4);

        // len beyond WIDTH clamps to 8 bits
        clr_cnt();
        go("len12", 8'h96, 4'd12, 4'd0);
        run("len12", 9);
        chk_int("len12_busy_g1", bc0, 8);

        // asynchronous reset in the middle of an 8-bit transmission
        clr_cnt();
        go("arst", 8'hB4, 4'd8, 4'd0);
        run("arst", 2);
        #1 rst = 1'b1;
        #1 chk("arst_async");
        start = 1'b1;
        run("arst_hold", 2);
        start = 1'b0;
        rst   = 1'b0;
        run("arst_after", 3);
        chk_int("arst_no_done", dc0 + dc1, 0);
        clr_cnt();
        go("arst_new", 8'h6D, 4'd8, 4'd1);
        run("arst_new", 18);
        chk_int("arst_new_busy_g1", bc0, 17);

        // randomized transmissions with inputs scrambled while busy
        for (int t = 0; t < 25; t++) begin
            go("rand", 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            k = 0;
            while ((m_act[0] || m_act[1]) && k < 200) begin
                pattern    = 8'($urandom);
                len        = 4'($urandom);
                repeat_cnt = 4'($urandom);
                tick("rand");
                k++;
            end
            nchk++;
            assert (k < 200) npass++;
            else $error("FAIL rand_timeout cycles %0d limit %0d", k, 200);
            run("rand_idle", $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/moore_sequence_generator.md
MOORE_SEQUENCE_GENERATOR -- requirements
Module: moore_sequence_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, maximum pattern length in bits (2..15).
REQ-002 SHALL have parameter GAP, default 1, number of idle (x_out=0) cycles between repeats (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a transmission; sampled on rising edge of clk.
REQ-006 SHALL have port pattern  input  WIDTH  bit sequence to emit, MSB-first from bit len-1.
REQ-007 SHALL have port len  input  4  pattern length in bits.
REQ-008 SHALL have port repeat_cnt  input  4  extra repetitions (total transmissions = repeat_cnt+1).
REQ-009 SHALL have port x_out  output  1  serial bit stream, registered, one bit per clock.
REQ-010 SHALL have port busy  output  1  high while pattern bits or gap cycles are being driven.
REQ-011 SHALL have port done  output  1  single-cycle pulse after the final bit.

Function
REQ-012 SHALL be a Moore machine: x_out, busy and done driven only from registers, never combinationally from inputs.
REQ-013 SHALL implement states IDLE, SHIFT, GAP, DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge, capture pattern, effective length and repeat_cnt, load bit len_eff-1 into x_out, set busy=1 and enter SHIFT at that same edge.
REQ-015 SHALL, in IDLE with start=0, hold x_out=0, busy=0, done=0.
REQ-016 SHALL use effective length len_eff = WIDTH when len=0 or len>WIDTH, else len.
REQ-017 SHALL, in SHIFT, hold each bit for exactly one cycle, emitting bits len_eff-1 down to 0 from the captured copy.
REQ-018 SHALL ignore changes on pattern, len and repeat_cnt after capture.
REQ-019 SHALL, after bit 0 of a transmission with repeats remaining and GAP>0, enter GAP: x_out=0, busy=1, for exactly GAP cycles, then restart SHIFT at bit len_eff-1.
REQ-020 SHALL, with GAP=0 and repeats remaining, emit bit len_eff-1 of the next repeat in the cycle immediately after bit 0.
REQ-021 SHALL decrement the remaining-repeat counter once per completed transmission; no wrap below zero.
REQ-022 SHALL, after bit 0 of the final transmission, enter DONE for one cycle: x_out=0, busy=0, done=1; then IDLE.
REQ-023 SHALL ignore start in SHIFT, GAP and DONE; a start held high through DONE is accepted on the first IDLE edge.
REQ-024 SHALL produce latency of exactly one clock from the start-sampling edge to the first bit on x_out.
REQ-025 SHALL produce total busy duration of (repeat_cnt+1)*len_eff + repeat_cnt*GAP cycles.

Reset
REQ-026 SHALL, on rst=1, immediately (without waiting for clk) force state IDLE, x_out=0, busy=0, done=0 and clear bit and repeat counters.
REQ-027 SHALL, on rst asserted mid-transmission, abort with no done pulse; after release, remain in IDLE until a new start.
REQ-028 SHALL ignore start while rst=1.

Verification
REQ-029 SHALL test: pattern=8'b0000_0101, len=3, repeat_cnt=0, start one cycle -> x_out 1,0,1 on cycles 1-3, busy high cycles 1-3, done=1 cycle 4, idle cycle 5.
REQ-030 SHALL test: pattern=8'hA5, len=0, repeat_cnt=1, GAP=1 -> 1,0,1,0,0,1,0,1, gap 0, then 1,0,1,0,0,1,0,1; busy 17 cycles; single done pulse.
REQ-031 SHALL test: GAP=0, pattern=3'b110, len=3, repeat_cnt=2 -> 110110110 back-to-back, busy 9 cycles, done cycle 10.
REQ-032 SHALL test: start pulsed again during SHIFT and pattern changed mid-transmission -> output stream unchanged, no restart.
REQ-033 SHALL test: rst asserted between clock edges during bit 2 of len=8 -> x_out and busy 0 before next edge, no done; new start afterwards transmits normally.
REQ-034 SHALL test: len=12 with WIDTH=8 -> 8 bits emitted, busy 8 cycles.
